// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, one stop bit, line idles high.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int BIT_PERIOD = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [7:0] CNT_MAX = 8'(BIT_PERIOD - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [2:0] idx, idx_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       serial_nxt;
    logic       done_nxt;
    logic       bit_end;
`ifdef UART_TX_PARITY_EN
    logic       parity_bit, parity_nxt;
`endif

    assign tx_busy = (state != IDLE);
    assign bit_end = (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            serial_out <= 1'b1;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shreg      <= shreg_nxt;
            serial_out <= serial_nxt;
            tx_done    <= done_nxt;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_nxt;
`endif
        end
    end

    // The line value for the coming bit is decided here so serial_out only moves at bit boundaries.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        shreg_nxt  = shreg;
        serial_nxt = serial_out;
        done_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt = parity_bit;
`endif
        case (state)
            IDLE: begin
                serial_nxt = 1'b1;
                if (tx_start) begin
                    state_nxt  = START;
                    shreg_nxt  = tx_data;
                    cnt_nxt    = '0;
                    idx_nxt    = '0;
                    serial_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_nxt = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt  = DATA;
                    cnt_nxt    = '0;
                    serial_nxt = shreg[0];
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt  = PARITY;
                        serial_nxt = parity_bit;
`else
                        state_nxt  = STOP;
                        serial_nxt = 1'b1;
`endif
                    end else begin
                        idx_nxt    = idx + 3'd1;
                        shreg_nxt  = {1'b0, shreg[7:1]};
                        serial_nxt = shreg[1];
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt  = STOP;
                    cnt_nxt    = '0;
                    serial_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    serial_nxt = 1'b1;
                    done_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                serial_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: expected bytes are queued when a frame is requested
// and compared slot by slot against the serial line.
module tb_uart_tx;

    localparam int BP = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NSLOT = 11;
`else
    localparam int NSLOT = 10;
`endif

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       serial_out, tx_busy, tx_done;
    logic [7:0] tx_data2 = 8'h00;
    logic       tx_start2 = 1'b0;
    logic       serial_out2, tx_busy2, tx_done2;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    uart_tx #(.BIT_PERIOD(BP)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .serial_out(serial_out), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx #(.BIT_PERIOD(2)) dut_min (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_start(tx_start2),
        .serial_out(serial_out2), .tx_busy(tx_busy2), .tx_done(tx_done2)
    );

    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic slotBit(input logic [7:0] d, input int s);
        if (s == 0) return 1'b0;
        if (s >= 1 && s <= 8) return d[s-1];
        if (NSLOT == 11 && s == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input bit push);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        if (push) exp_q.push_back(d);
    endtask

    // Called in the request cycle; returns in the tx_done cycle.
    task automatic receiveFrame(input bit hold);
        logic [7:0] exp_byte;
        logic [7:0] rx;
        logic       e;
        int         good, busy_cnt, done_cnt;
        if (exp_q.size() == 0) begin
            checkOutput("sb_empty", 0, 1);
            return;
        end
        exp_byte = exp_q.pop_front();
        rx = 8'h00;
        busy_cnt = 0;
        done_cnt = 0;
        for (int s = 0; s < NSLOT; s++) begin
            e = slotBit(exp_byte, s);
            good = 0;
            for (int c = 0; c < BP; c++) begin
                @(negedge clk);
                if (!hold && s == 0 && c == 0) tx_start = 1'b0;
                if (serial_out === e) good++;
                if (tx_busy === 1'b1) busy_cnt++;
                if (tx_done !== 1'b0) done_cnt++;
                if (s >= 1 && s <= 8 && c == BP / 2) rx[s-1] = serial_out;
            end
            checkOutput($sformatf("slot%0d_%02h", s, exp_byte), good, BP);
        end
        checkOutput("busy_cycles", busy_cnt, NSLOT * BP);
        checkOutput("early_done", done_cnt, 0);
        checkOutput("rx_byte", {24'h0, rx}, {24'h0, exp_byte});
        @(negedge clk);
        checkOutput("done_pulse", {31'h0, tx_done}, 1);
        checkOutput("done_busy", {31'h0, tx_busy}, 0);
        checkOutput("done_line", {31'h0, serial_out}, 1);
    endtask

    initial begin
        int done_cnt, line_bad, low_good, high_good, busy_cnt;

        // Reset with no clock edges at all.
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_line", {31'h0, serial_out}, 1);
        checkOutput("rst_busy", {31'h0, tx_busy}, 0);
        checkOutput("rst_done", {31'h0, tx_done}, 0);
        #1 rst = 1'b0;

        // Request pending before the first edge after reset release.
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        exp_q.push_back(8'hA5);
        #1 clk_run = 1'b1;
        receiveFrame(1'b0);
        @(negedge clk);
        checkOutput("done_once", {31'h0, tx_done}, 0);

        applyStimulus(8'h07, 1'b1);
        receiveFrame(1'b0);

        // Start held high and data changed mid-frame; next frame must follow the done cycle.
        applyStimulus(8'hA5, 1'b1);
        fork
            receiveFrame(1'b1);
            begin
                repeat (40) @(negedge clk);
                tx_data = 8'h3C;
                exp_q.push_back(8'h3C);
            end
        join
        receiveFrame(1'b0);

        // Reset in the middle of a frame.
        applyStimulus(8'hA5, 1'b0);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (54) @(negedge clk);
        checkOutput("pre_rst_line", {31'h0, serial_out}, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_line", {31'h0, serial_out}, 1);
        checkOutput("mid_rst_busy", {31'h0, tx_busy}, 0);
        done_cnt = 0;
        line_bad = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (NSLOT * BP) begin
            @(negedge clk);
            if (tx_done !== 1'b0) done_cnt++;
            if (serial_out !== 1'b1) line_bad++;
        end
        checkOutput("abort_no_done", done_cnt, 0);
        checkOutput("abort_line_idle", line_bad, 0);
        applyStimulus(8'hFF, 1'b1);
        receiveFrame(1'b0);

        // Minimum bit period with an all-zero byte.
        @(negedge clk);
        tx_data2  = 8'h00;
        tx_start2 = 1'b1;
        low_good  = 0;
        high_good = 0;
        busy_cnt  = 0;
        for (int cyc = 1; cyc <= NSLOT * 2; cyc++) begin
            @(negedge clk);
            if (cyc == 1) tx_start2 = 1'b0;
            if (cyc <= (NSLOT - 1) * 2 && serial_out2 === 1'b0) low_good++;
            if (cyc > (NSLOT - 1) * 2 && serial_out2 === 1'b1) high_good++;
            if (tx_busy2 === 1'b1) busy_cnt++;
        end
        checkOutput("min_low", low_good, (NSLOT - 1) * 2);
        checkOutput("min_stop", high_good, 2);
        checkOutput("min_busy", busy_cnt, NSLOT * 2);
        @(negedge clk);
        checkOutput("min_done", {31'h0, tx_done2}, 1);

        checkOutput("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter BIT_PERIOD, default 10, giving the clock cycles per serial bit; the legal range is 2..255.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 SHALL provide port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 SHALL provide port tx_data, input, 8 bits: the byte to transmit, sampled only when tx_start is accepted.
REQ-005 SHALL provide port tx_start, input, 1 bit: the transmit request, level-sampled each cycle.
REQ-006 SHALL provide port serial_out, output, 1 bit: the UART line; it idles high and is driven directly from a flop.
REQ-007 SHALL provide port tx_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 SHALL provide port tx_done, output, 1 bit: a one-cycle pulse when a frame completes.

Function
REQ-009 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-010 SHALL, in IDLE with tx_start=1, latch tx_data into an 8-bit shift register and enter START on the next edge; tx_start is accepted only in IDLE.
REQ-011 SHALL ignore tx_start while tx_busy=1, with no queuing and no effect on the frame in flight.
REQ-012 SHALL hold serial_out=0 for exactly BIT_PERIOD cycles in START, beginning the cycle after acceptance (latency from accept to the start-bit edge: 1 cycle).
REQ-013 SHALL, in DATA, send 8 bits LSB first, each held for exactly BIT_PERIOD cycles, shifting once per bit boundary.
REQ-014 SHALL keep a bit-period counter that counts 0..BIT_PERIOD-1, wraps to 0 at each bit boundary, and is cleared on acceptance.
REQ-015 SHALL keep a 3-bit bit index that increments per data bit; the transition out of DATA occurs when index 7 completes its period.
REQ-016 SHALL, in STOP, hold serial_out=1 for exactly BIT_PERIOD cycles and then return to IDLE.
REQ-017 SHALL assert tx_done for exactly one cycle: the first IDLE cycle after STOP.
REQ-018 SHALL accept a tx_start present in that tx_done cycle, so back-to-back frames have zero idle bit-times between the stop bit and the next start bit.
REQ-019 SHALL not alter the shift register or the frame when tx_data changes after acceptance.
REQ-020 SHALL keep serial_out glitch-free: it changes only at bit boundaries.

Reset
REQ-021 SHALL, on rst=1, immediately and regardless of clk, force state=IDLE, serial_out=1, tx_busy=0, tx_done=0, counter=0, index=0 and shift register=0.
REQ-022 SHALL, when rst is asserted mid-frame, abort the frame with no tx_done; the line returns high at once.
REQ-023 SHALL treat the first rising clk edge after rst deasserts as a normal IDLE cycle in which tx_start can be accepted.

Configuration
REQ-024 SHALL, with macro UART_TX_PARITY_EN defined, go DATA->PARITY->STOP, sending one even-parity bit (XOR of the 8 latched data bits) for BIT_PERIOD cycles; the frame is 11 bit-times.
REQ-025 SHALL, with UART_TX_PARITY_EN undefined, go DATA->STOP directly, compile no PARITY state or parity logic, and send a 10-bit-time frame.

Verification
REQ-026 SHALL cover reset: rst pulsed with no clk edges -> serial_out=1, tx_busy=0, tx_done=0 immediately.
REQ-027 SHALL cover a single frame without parity, BIT_PERIOD=10: tx_data=0xA5 with tx_start for 1 cycle at cycle 0 -> serial_out is 0 for cycles 1-10, then bits 1,0,1,0,0,1,0,1 in 10-cycle slots over cycles 11-90, 1 for cycles 91-100, tx_done=1 at cycle 101, and tx_busy high for cycles 1-100.
REQ-028 SHALL cover parity, BIT_PERIOD=10: tx_data=0x07 -> parity slot (cycles 91-100) =1, stop bit at cycles 101-110, and tx_done at cycle 111; tx_data=0xA5 -> parity slot =0.
REQ-029 SHALL cover busy rejection: tx_start held high with tx_data changed to 0x3C at cycle 40 of an 0xA5 frame -> the 0xA5 frame is unaffected, then 0x3C starts at the tx_done cycle+1 with no idle gap.
REQ-030 SHALL cover mid-frame reset: rst asserted at cycle 55 of a frame -> serial_out=1 asynchronously, no tx_done, and a new 0xFF frame is then sent correctly.
REQ-031 SHALL cover minimum BIT_PERIOD=2: tx_data=0x00 -> start and all data bits low for 18 cycles total, stop high for 2 cycles, tx_done at cycle 21.
